// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types for the PLL lock sequencer: state encoding visible on state_o
// and a small helper used to size the sequencing counter.
package pll_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; both stages clear on
// reset so the first qualified sample after reset is always 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_p0;
   logic [WIDTH-1:0] sync_p1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         // stage 0: capture, stage 1: resolved output
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up and recovers the PLL: pulses RESETB, qualifies LOCK, releases the
// downstream domain, retries on timeout and latches a fault after repeated failures.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RESET_CYCLES = 16,
   parameter int LOCK_TIMEOUT     = 4096,
   parameter int STABLE_CYCLES    = 1024,
   parameter int MAX_RETRIES      = 3,
   localparam int RETRY_W = $clog2(MAX_RETRIES + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pll_locked,
   input  logic               relock,
   output logic               pll_resetb,
   output logic               ready,
   output logic               fault,
   output logic [STATE_W-1:0] state_o,
   output logic [RETRY_W-1:0] retry_count,
   output logic [7:0]         lock_loss_count
);

   localparam int CNT_W = $clog2(max3(PLL_RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
   localparam logic [7:0]         LOSS_MAX  = 8'hFF;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [RETRY_W-1:0] retry_nxt, retry_inc;
   logic [7:0]         loss_nxt;
   logic               locked_s;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pll_locked),
      .q       (locked_s)
   );

   assign retry_inc = retry_count + RETRY_W'(1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= RESET_PLL;
         cnt             <= '0;
         retry_count     <= '0;
         lock_loss_count <= '0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         retry_count     <= retry_nxt;
         lock_loss_count <= loss_nxt;
      end
   end

   // relock pre-empts every state transition, including a lock loss in RUN
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry_count;
      loss_nxt  = lock_loss_count;
      if (relock) begin
         state_nxt = RESET_PLL;
         cnt_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            RESET_PLL: begin
               if (cnt == RST_LAST) begin
                  state_nxt = WAIT_LOCK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_nxt = STABILIZE;
                  cnt_nxt   = '0;
               end else if (cnt == TMO_LAST) begin
                  retry_nxt = retry_inc;
                  state_nxt = (retry_inc == RETRY_MAX) ? FAULT : RESET_PLL;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            STABILIZE: begin
               // a glitch restarts the lock window but is not a failed attempt
               if (!locked_s) begin
                  state_nxt = WAIT_LOCK;
                  cnt_nxt   = '0;
               end else if (cnt == STB_LAST) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
                  retry_nxt = '0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
            RUN: begin
               if (!locked_s) begin
                  if (lock_loss_count != LOSS_MAX) begin
                     loss_nxt = lock_loss_count + 8'd1;
                  end
                  state_nxt = RESET_PLL;
                  cnt_nxt   = '0;
               end
            end
            FAULT: begin
               state_nxt = FAULT;
            end
            default: begin
               state_nxt = RESET_PLL;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign pll_resetb = (state != RESET_PLL) && (state != FAULT);
   assign ready      = (state == RUN);
   assign fault      = (state == FAULT);
   assign state_o    = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: per-cycle check against a phase/elapsed-time
// model plus directed scenarios with hand-computed cycle expectations.
module tb_pll_lock_sequencer;

   localparam int PRC = 4;
   localparam int LTO = 16;
   localparam int STC = 8;
   localparam int MR  = 2;

   localparam int P_RST   = 0;
   localparam int P_WAIT  = 1;
   localparam int P_STAB  = 2;
   localparam int P_RUN   = 3;
   localparam int P_FAULT = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       relock = 1'b0;
   logic       pll_resetb, ready, fault;
   logic [2:0] state_o;
   logic [1:0] retry_count;
   logic [7:0] lock_loss_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pll_lock_sequencer #(
      .PLL_RESET_CYCLES (PRC),
      .LOCK_TIMEOUT     (LTO),
      .STABLE_CYCLES    (STC),
      .MAX_RETRIES      (MR)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .pll_locked      (pll_locked),
      .relock          (relock),
      .pll_resetb      (pll_resetb),
      .ready           (ready),
      .fault           (fault),
      .state_o         (state_o),
      .retry_count     (retry_count),
      .lock_loss_count (lock_loss_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: phase plus cycles spent in it; lock seen through a sample history.
   int m_ph, m_el, m_retry, m_loss;
   int hist[$];
   bit m_live = 1'b0;

   task automatic model_edge();
      int ls;
      if (!reset_n) begin
         m_ph = P_RST; m_el = 0; m_retry = 0; m_loss = 0;
         hist.delete();
         m_live = 1'b1;
         return;
      end
      ls = (hist.size() >= 2) ? hist[hist.size()-2] : 0;
      hist.push_back(int'(pll_locked));
      if (hist.size() > 3) hist.delete(0);
      if (relock) begin
         m_ph = P_RST; m_el = 0; m_retry = 0;
         return;
      end
      case (m_ph)
         P_RST: begin
            m_el++;
            if (m_el == PRC) begin m_ph = P_WAIT; m_el = 0; end
         end
         P_WAIT: begin
            if (ls != 0) begin
               m_ph = P_STAB; m_el = 0;
            end else begin
               m_el++;
               if (m_el == LTO) begin
                  m_retry++;
                  m_ph = (m_retry == MR) ? P_FAULT : P_RST;
                  m_el = 0;
               end
            end
         end
         P_STAB: begin
            if (ls == 0) begin
               m_ph = P_WAIT; m_el = 0;
            end else begin
               m_el++;
               if (m_el == STC) begin m_ph = P_RUN; m_el = 0; m_retry = 0; end
            end
         end
         P_RUN: begin
            if (ls == 0) begin
               if (m_loss < 255) m_loss++;
               m_ph = P_RST; m_el = 0;
            end
         end
         default: ;
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_edge();
         #1;
         if (m_live) begin
            chk("state_o", int'(state_o), m_ph);
            chk("pll_resetb", int'(pll_resetb), (m_ph != P_RST && m_ph != P_FAULT) ? 1 : 0);
            chk("ready", int'(ready), (m_ph == P_RUN) ? 1 : 0);
            chk("fault", int'(fault), (m_ph == P_FAULT) ? 1 : 0);
            chk("retry_count", int'(retry_count), m_retry);
            chk("lock_loss_count", int'(lock_loss_count), m_loss);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_obs(input int code, input int limit, input string name);
      int k = 0;
      while (int'(state_o) != code && k < limit) begin
         tick();
         k++;
      end
      chk(name, int'(state_o), code);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, int'(state_o), 0);
      chk({tag, "_resetb"}, int'(pll_resetb), 0);
      chk({tag, "_ready"}, int'(ready), 0);
      chk({tag, "_fault"}, int'(fault), 0);
      chk({tag, "_retry"}, int'(retry_count), 0);
      chk({tag, "_loss"}, int'(lock_loss_count), 0);
      chk({tag, "_sync0"}, int'(dut.u_lock_sync.meta_p0), 0);
      chk({tag, "_sync1"}, int'(dut.u_lock_sync.sync_p1), 0);
   endtask

   initial begin
      // 1: clean bring-up with lock present throughout
      reset_n = 1'b0; pll_locked = 1'b1; relock = 1'b0;
      tick(3);
      reset_n = 1'b1;
      for (int c = 0; c <= 14; c++) begin
         chk("t1_resetb", int'(pll_resetb), (c >= 4) ? 1 : 0);
         if (c == 5 || c == 12) chk("t1_stab", int'(state_o), 2);
         if (c == 12) chk("t1_ready_lo", int'(ready), 0);
         if (c == 13) begin
            chk("t1_run", int'(state_o), 3);
            chk("t1_ready", int'(ready), 1);
            chk("t1_retry", int'(retry_count), 0);
         end
         tick();
      end

      // 2: lock never arrives -> two timed-out attempts -> FAULT, then relock
      reset_n = 1'b0; pll_locked = 1'b0;
      tick(2);
      reset_n = 1'b1;
      for (int c = 0; c <= 44; c++) begin
         if (c == 20) begin
            chk("t2_retry1_state", int'(state_o), 0);
            chk("t2_retry1", int'(retry_count), 1);
         end
         if (c == 39) chk("t2_wait_last", int'(state_o), 1);
         if (c == 40 || c == 44) begin
            chk("t2_fault_state", int'(state_o), 4);
            chk("t2_fault", int'(fault), 1);
            chk("t2_resetb", int'(pll_resetb), 0);
            chk("t2_retry", int'(retry_count), 2);
            chk("t2_ready", int'(ready), 0);
         end
         tick();
      end
      relock = 1'b1;
      tick();
      relock = 1'b0;
      chk("t2_relock_state", int'(state_o), 0);
      chk("t2_relock_retry", int'(retry_count), 0);
      chk("t2_relock_fault", int'(fault), 0);

      // 3: single-cycle lock drop in RUN
      pll_locked = 1'b1;
      wait_obs(3, 100, "t3_run");
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      chk("t3_ready_d1", int'(ready), 1);
      tick();
      chk("t3_ready_d2", int'(ready), 1);
      tick();
      chk("t3_ready_d3", int'(ready), 0);
      chk("t3_loss", int'(lock_loss_count), 1);
      chk("t3_resetb_d3", int'(pll_resetb), 0);
      tick(3);
      chk("t3_resetb_d6", int'(pll_resetb), 0);
      tick();
      chk("t3_resetb_d7", int'(pll_resetb), 1);
      wait_obs(3, 100, "t3_requal");
      chk("t3_ready_again", int'(ready), 1);

      // 4: glitch at the 5th stable cycle
      relock = 1'b1;
      tick();
      relock = 1'b0;
      wait_obs(2, 50, "t4_stab");
      tick(2);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      chk("t4_still_stab", int'(state_o), 2);
      tick();
      chk("t4_back_wait", int'(state_o), 1);
      chk("t4_retry", int'(retry_count), 0);
      tick();
      chk("t4_restab", int'(state_o), 2);
      tick(7);
      chk("t4_stab_last", int'(state_o), 2);
      chk("t4_ready_lo", int'(ready), 0);
      tick();
      chk("t4_run", int'(state_o), 3);
      chk("t4_ready", int'(ready), 1);

      // 5: relock coinciding with lock loss, then saturate the loss counter
      pll_locked = 1'b0;
      tick(2);
      relock = 1'b1;
      tick();
      relock = 1'b0;
      chk("t5_relock_state", int'(state_o), 0);
      chk("t5_loss_kept", int'(lock_loss_count), 1);
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b1;
         wait_obs(3, 60, "t5_run");
         pll_locked = 1'b0;
         wait_obs(0, 10, "t5_loss");
      end
      chk("t5_loss_sat", int'(lock_loss_count), 255);

      // 6: reset mid-STABILIZE and in RUN
      pll_locked = 1'b1;
      wait_obs(2, 60, "t6_stab");
      tick(2);
      reset_n = 1'b0;
      tick();
      chk_reset_vals("t6a");
      reset_n = 1'b1;
      wait_obs(3, 60, "t6_run");
      reset_n = 1'b0;
      tick();
      chk_reset_vals("t6b");
      reset_n = 1'b1;
      tick(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
